// File: rtl/demux_wr_sched_32.sv
// Dual-lane write scheduler: buffers up to two requests per cycle in order and
// presents one per cycle to a 32-bit 1-to-8 demux, popping on destination ready.
module demux_wr_sched_32 #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    input  logic [2:0]                 a_sel,
    input  logic [31:0]                a_data,
    input  logic                       b_valid,
    input  logic [2:0]                 b_sel,
    input  logic [31:0]                b_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [2:0]                 out_sel,
    output logic [31:0]                out_data,
    output logic [7:0]                 out_en,
    input  logic [7:0]                 dst_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    r_sel_mem  [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_drop_err;

    logic          w_in_ready;
    logic          w_push_a;
    logic          w_push_b;
    logic [AW-1:0] w_b_addr;
    logic [CW-1:0] w_npush;
    logic          w_out_valid;
    logic [2:0]    w_head_sel;
    logic [31:0]   w_head_data;
    logic          w_pop;
    logic [7:0]    w_out_en;

    // Room for two is judged from the registered count only, so a pop in the
    // same cycle never widens the acceptance window.
    assign w_in_ready  = (r_count <= CW'(DEPTH - 2));
    assign w_push_a    = w_in_ready & a_valid;
    assign w_push_b    = w_in_ready & b_valid;
    assign w_b_addr    = a_valid ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
    assign w_npush     = CW'(w_push_a) + CW'(w_push_b);

    assign w_out_valid = (r_count != '0);
    assign w_head_sel  = w_out_valid ? r_sel_mem[r_rd_ptr]  : 3'd0;
    assign w_head_data = w_out_valid ? r_data_mem[r_rd_ptr] : 32'd0;
    assign w_pop       = w_out_valid & dst_ready[w_head_sel];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_en
            assign w_out_en[gi] = w_out_valid && (w_head_sel == 3'(gi));
        end
    endgenerate

    // Storage is deliberately left out of reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_sel_mem[r_wr_ptr]  <= a_sel;
            r_data_mem[r_wr_ptr] <= a_data;
        end
        if (w_push_b) begin
            r_sel_mem[w_b_addr]  <= b_sel;
            r_data_mem[w_b_addr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_npush);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + w_npush - CW'(w_pop);
            if ((a_valid | b_valid) & ~w_in_ready)
                r_drop_err <= 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_sel   = w_head_sel;
    assign out_data  = w_head_data;
    assign out_en    = w_out_en;
    assign count     = r_count;
    assign drop_err  = r_drop_err;
endmodule

// File: tb/tb_demux_wr_sched_32.sv
// Scoreboard bench for demux_wr_sched_32: stimulus queues expected pops, a
// negedge monitor compares every accepted transfer in order.
module tb_demux_wr_sched_32;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [2:0]  a_sel, b_sel;
    logic [31:0] a_data, b_data;
    logic        in_ready, out_valid, drop_err;
    logic [2:0]  out_sel;
    logic [31:0] out_data;
    logic [7:0]  out_en, dst_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    logic [34:0] exp_q [$];

    demux_wr_sched_32 #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data),
        .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_sel(out_sel),
        .out_data(out_data), .out_en(out_en), .dst_ready(dst_ready),
        .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end else
            $display("ok   %s = 0x%0h", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0;
        a_sel = 0; b_sel = 0; a_data = 0; b_data = 0;
    endtask

    task automatic set_a(input logic [2:0] s, input logic [31:0] d, input bit expect_push);
        a_valid = 1; a_sel = s; a_data = d;
        if (expect_push) exp_q.push_back({s, d});
    endtask

    task automatic set_b(input logic [2:0] s, input logic [31:0] d);
        b_valid = 1; b_sel = s; b_data = d;
        exp_q.push_back({s, d});
    endtask

    // Monitor: one-hot enable always, and in-order data on every accepted pop.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            logic [7:0] en_exp;
            en_exp = 8'd1 << out_sel;
            checks++;
            if (out_en !== en_exp) begin
                failures++;
                $display("FAIL out_en_decode actual=0x%0h required=0x%0h", out_en, en_exp);
            end
            if (dst_ready[out_sel]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual sel=%0d data=0x%0h required=none", out_sel, out_data);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    if ({out_sel, out_data} !== e) begin
                        failures++;
                        $display("FAIL sb_pop actual sel=%0d data=0x%0h required sel=%0d data=0x%0h",
                                 out_sel, out_data, e[34:32], e[31:0]);
                    end else
                        $display("pop  sel=%0d data=0x%08h", out_sel, out_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; dst_ready = 8'h00; idle();
        step(); step();
        rst = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_en", 32'(out_en), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_drop_err", 32'(drop_err), 0);

        // Single A push, visible next cycle, popped immediately.
        dst_ready = 8'hFF;
        set_a(3'd5, 32'hDEADBEEF, 1);
        step(); idle();
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_sel", 32'(out_sel), 5);
        chk("t1_out_en", 32'(out_en), 32'h20);
        chk("t1_out_data", out_data, 32'hDEADBEEF);
        step();
        chk("t1_count", 32'(count), 0);
        chk("t1_out_en_idle", 32'(out_en), 0);

        // Dual push: A then B.
        set_a(3'd1, 32'h11, 1); set_b(3'd2, 32'h22);
        step(); idle();
        chk("t2_en_a", 32'(out_en), 32'h02);
        chk("t2_data_a", out_data, 32'h11);
        step();
        chk("t2_en_b", 32'(out_en), 32'h04);
        chk("t2_data_b", out_data, 32'h22);
        step();
        chk("t2_count", 32'(count), 0);

        // Head-of-line blocking on sel=3.
        dst_ready = 8'hF7;
        set_a(3'd3, 32'h33, 1); set_b(3'd4, 32'h44);
        step(); idle();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_count", 32'(count), 2);
            chk("t3_hold_sel", 32'(out_sel), 3);
            step();
        end
        dst_ready = 8'hFF;
        step();
        chk("t3_next_sel", 32'(out_sel), 4);
        step();
        chk("t3_count", 32'(count), 0);

        // Fill to full, overflow attempt, drain.
        dst_ready = 8'h00;
        set_a(3'd0, 32'hA0, 1); set_b(3'd1, 32'hB1);
        step();
        set_a(3'd2, 32'hA2, 1); set_b(3'd3, 32'hB3);
        step(); idle();
        chk("t4_full_count", 32'(count), 4);
        chk("t4_full_in_ready", 32'(in_ready), 0);
        set_a(3'd7, 32'h77, 0);
        step(); idle();
        chk("t4_drop_err", 32'(drop_err), 1);
        chk("t4_drop_count", 32'(count), 4);
        dst_ready = 8'hFF;
        for (int i = 3; i >= 0; i--) begin
            step();
            chk("t4_drain_count", 32'(count), 32'(i));
        end
        chk("t4_drop_sticky", 32'(drop_err), 1);

        // Steady state: one push and one pop per cycle across pointer wraps.
        set_a(3'd0, 32'h1000, 1);
        step();
        for (int i = 0; i < 20; i++) begin
            set_a(3'(i % 8), 32'h2000 + 32'(i), 1);
            step();
            chk("t5_steady_count", 32'(count), 1);
        end
        idle();
        step();
        chk("t5_count", 32'(count), 0);

        // Reset mid-operation with three queued entries.
        dst_ready = 8'h00;
        set_a(3'd5, 32'h55, 1); set_b(3'd6, 32'h66);
        step(); idle();
        set_a(3'd7, 32'h77, 1);
        step(); idle();
        chk("t6_pre_count", 32'(count), 3);
        rst = 1;
        step();
        rst = 0;
        exp_q.delete();
        chk("t6_count", 32'(count), 0);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_en", 32'(out_en), 0);
        chk("t6_drop_err", 32'(drop_err), 0);
        chk("t6_in_ready", 32'(in_ready), 1);

        step();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
